// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the multi-limb adder sequencer.
//   state_t       : sequencer FSM encoding (IDLE, RUN, DONE)
//   N_DEFAULT     : default limb width
//   WORDS_DEFAULT : default limb count
//   idx_width()   : limb-index width, never below 1 bit
package adder_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned N_DEFAULT     = 10;
  localparam int unsigned WORDS_DEFAULT = 4;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Requester <-> sequencer handshake bundle.
//   start/a/b/cin(/op) : request and operands, driven by the master
//   busy/done/sum/cout : status and result, driven by the slave
// Optional feature macro: ADDSEQ_SUB_EN adds the op (0=add, 1=subtract) signal.
interface adder_seq_ctrl_if
  import adder_seq_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned WORDS = WORDS_DEFAULT
);
  localparam int unsigned W = N * WORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef ADDSEQ_SUB_EN
  logic         op;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

`ifdef ADDSEQ_SUB_EN
  modport master (output start, a, b, cin, op, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, op, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/adder.sv
// N-bit ripple-carry adder (pure combinational).
//   i_a, i_b : addends      i_ci : carry in
//   o_s      : sum          o_co : carry out of the top bit
module adder #(
  parameter int unsigned N = 10
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_ci,
  output logic [N-1:0] o_s,
  output logic         o_co
);

  logic w_c;

  always_comb begin
    w_c = i_ci;
    o_s = '0;
    for (int unsigned k = 0; k < N; k++) begin
      o_s[k] = i_a[k] ^ i_b[k] ^ w_c;
      w_c    = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
    end
    o_co = w_c;
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WORDS*N-bit adder built on one shared N-bit ripple adder,
// processing one limb per cycle with the carry registered between limbs.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   io_bus : slave side of adder_seq_ctrl_if (start/a/b/cin[/op] in,
//            busy/done/sum/cout out)
// Optional feature macro: ADDSEQ_SUB_EN enables op=1 subtraction (A-B).
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned WORDS = WORDS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_seq_ctrl_if.slave  io_bus
);

  localparam int unsigned W    = N * WORDS;
  localparam int unsigned IW   = idx_width(WORDS);
  localparam int unsigned BW   = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned LAST = WORDS - 1;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a, r_b, r_sum;
  logic            r_carry, r_cout, r_sub;

  logic            w_op;
  logic            w_last;
  logic [BW-1:0]   w_base;
  logic [N-1:0]    w_a_limb, w_b_limb, w_s;
  logic            w_co;

`ifdef ADDSEQ_SUB_EN
  assign w_op = io_bus.op;
`else
  assign w_op = 1'b0;
`endif

  assign w_last   = (r_idx == IW'(LAST));
  assign w_base   = BW'(r_idx * N);
  assign w_a_limb = r_a[w_base +: N];
  // Subtraction is A + ~B + 1; the +1 enters as the limb-0 carry latched on start.
  assign w_b_limb = r_b[w_base +: N] ^ {N{r_sub}};

  adder #(.N(N)) u_adder (
    .i_a  (w_a_limb),
    .i_b  (w_b_limb),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (io_bus.start) w_state_nxt = RUN;
      RUN:     if (w_last)       w_state_nxt = DONE;
      DONE:                      w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_sub   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_a     <= io_bus.a;
            r_b     <= io_bus.b;
            r_idx   <= '0;
            r_sub   <= w_op;
            r_carry <= w_op ? 1'b1 : io_bus.cin;
          end
        end
        RUN: begin
          r_sum[w_base +: N] <= w_s;
          r_carry            <= w_co;
          // idx parks on the last limb rather than wrapping.
          if (w_last) r_cout <= w_co;
          else        r_idx  <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign io_bus.busy = (r_state != IDLE);
  assign io_bus.done = (r_state == DONE);
  assign io_bus.sum  = r_sum;
  assign io_bus.cout = r_cout;

endmodule
